// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues in-order word fetches and buffers
// responses in a small FIFO toward decode; wrong-path responses are dropped on redirect.
module if_fetch_stage #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int              FETCH_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr,
    output logic [6:0]      if_opcode
);
    localparam int CW = $clog2(FETCH_DEPTH + 1);
    localparam int PW = (FETCH_DEPTH > 1) ? $clog2(FETCH_DEPTH) : 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    logic [XLEN-1:0] pc;
    logic [CW-1:0]   outstanding, drop, count;
    logic [XLEN-1:0] pcq [FETCH_DEPTH];
    logic [PW-1:0]   pcq_wr, pcq_rd;
    fetch_entry_t    fifo [FETCH_DEPTH];
    logic [PW-1:0]   fifo_wr, fifo_rd;
    fetch_entry_t    head;

    logic            pop, req_fire, rsp_fire, rsp_drop, push;
    logic [CW:0]     credit;
    logic            unused_redirect_lsbs;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FETCH_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Credits count every slot already promised: in flight plus buffered, minus the one leaving.
    assign credit = {1'b0, outstanding} + {1'b0, count} - {{CW{1'b0}}, (if_valid & if_ready)};

    assign imem_req_valid = rst_n & ~redirect_valid & (credit < (CW+1)'(FETCH_DEPTH));
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid & imem_req_ready;

    assign rsp_fire = imem_rsp_valid & (outstanding != '0);
    assign rsp_drop = rsp_fire & (drop != '0);
    assign push     = rsp_fire & ~rsp_drop & ~redirect_valid;

    assign if_valid  = rst_n & (count != '0);
    assign pop       = if_valid & if_ready & ~redirect_valid;
    assign head      = fifo[fifo_rd];
    assign if_pc     = if_valid ? head.pc    : '0;
    assign if_instr  = if_valid ? head.instr : '0;
    assign if_opcode = if_instr[6:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            count       <= '0;
            pcq_wr      <= '0;
            pcq_rd      <= '0;
            fifo_wr     <= '0;
            fifo_rd     <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(rsp_fire);
            if (req_fire) begin
                pcq_wr <= ptr_inc(pcq_wr);
                pc     <= pc + XLEN'(4);
            end
            if (rsp_fire)
                pcq_rd <= ptr_inc(pcq_rd);

            if (redirect_valid) begin
                // Everything still in flight after this edge belongs to the old path.
                pc      <= {redirect_pc[XLEN-1:2], 2'b00};
                drop    <= outstanding - CW'(rsp_fire);
                count   <= '0;
                fifo_wr <= '0;
                fifo_rd <= '0;
            end else begin
                if (rsp_drop)
                    drop <= drop - CW'(1);
                if (push)
                    fifo_wr <= ptr_inc(fifo_wr);
                if (pop)
                    fifo_rd <= ptr_inc(fifo_rd);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire)
            pcq[pcq_wr] <= pc;
        if (push)
            fifo[fifo_wr] <= '{pc: pcq[pcq_rd], instr: imem_rsp_data};
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: variable-latency memory model plus a scoreboard
// of expected {pc, instr} pushed at request issue and popped as decode consumes.
module tb_if_fetch_stage;
    localparam int          XLEN  = 32;
    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid, imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_valid, if_ready = 1'b1;
    logic [31:0] if_pc, if_instr;
    logic [6:0]  if_opcode;

    if_fetch_stage #(.XLEN(XLEN), .RESET_PC(RPC), .FETCH_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready),
        .if_pc(if_pc), .if_instr(if_instr), .if_opcode(if_opcode)
    );

    always #5 clk = ~clk;

    int vec = 0;
    int errs = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h0000_1093;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Memory: in order, fixed latency 'lat' cycles from handshake edge to sampling edge.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t       mq[$];
    int          lat = 1;
    int          cyc = 0;
    bit          hs_next = 1'b0;
    logic [31:0] hs_addr = '0;

    always @(negedge clk) begin
        hs_next = (rst_n === 1'b1) && (imem_req_valid === 1'b1) && (imem_req_ready === 1'b1);
        hs_addr = imem_req_addr;
    end

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst_n !== 1'b1) mq.delete();
        else if (hs_next) mq.push_back('{hs_addr, cyc + lat});
        #1;
        if (mq.size() > 0 && mq[0].due <= cyc + 1) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    end

    // Scoreboard and protocol monitor, sampled mid-cycle.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;
    exp_t        sb[$];
    exp_t        e;
    logic [31:0] mpc = RPC;
    int          hs_cnt = 0;
    bit          hold_q = 1'b0, req_hold_q = 1'b0;
    logic [31:0] hold_pc, hold_instr, addr_hold;

    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
            chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
            chk("rst_if_pc", if_pc, 32'd0);
            chk("rst_if_instr", if_instr, 32'd0);
            chk("rst_if_opcode", {25'b0, if_opcode}, 32'd0);
            sb.delete();
            mpc = RPC;
            hold_q = 1'b0;
            req_hold_q = 1'b0;
        end else begin
            if (hold_q) begin
                chk("hold_valid", {31'b0, if_valid}, 32'd1);
                chk("hold_pc", if_pc, hold_pc);
                chk("hold_instr", if_instr, hold_instr);
            end
            if (req_hold_q) begin
                chk("req_hold_addr", imem_req_addr, addr_hold);
                chk("req_hold_valid", {31'b0, imem_req_valid | redirect_valid}, 32'd1);
            end
            if (redirect_valid)
                chk("redir_no_req", {31'b0, imem_req_valid}, 32'd0);
            if (if_valid && if_ready && !redirect_valid) begin
                chk("out_expected", {31'b0, sb.size() != 0}, 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("out_pc", if_pc, e.pc);
                    chk("out_instr", if_instr, e.instr);
                    chk("out_opcode", {25'b0, if_opcode}, {25'b0, e.instr[6:0]});
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                chk("req_addr", imem_req_addr, mpc);
                sb.push_back('{mpc, mem_word(mpc)});
                mpc = mpc + 32'd4;
                hs_cnt++;
            end
            if (redirect_valid) begin
                sb.delete();
                mpc = {redirect_pc[31:2], 2'b00};
            end
            hold_q     = if_valid && !if_ready && !redirect_valid;
            hold_pc    = if_pc;
            hold_instr = if_instr;
            req_hold_q = imem_req_valid && !imem_req_ready && !redirect_valid;
            addr_hold  = imem_req_addr;
        end
    end

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (if_valid !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'b0, if_valid}, 32'd1);
    endtask

    initial begin
        int base;
        logic [31:0] w;

        // Reset then streaming fetch from RESET_PC with 1-cycle memory
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        @(negedge clk);
        chk("s1_valid0", {31'b0, imem_req_valid}, 32'd1);
        chk("s1_addr0", imem_req_addr, 32'h0);
        @(negedge clk);
        chk("s1_addr1", imem_req_addr, 32'h4);
        @(negedge clk);
        chk("s1_addr2", imem_req_addr, 32'h8);
        chk("s2_first_valid", {31'b0, if_valid}, 32'd1);
        chk("s2_pc0", if_pc, 32'h0);
        @(negedge clk);
        chk("s2_pc1", if_pc, 32'h4);
        @(negedge clk);
        w = mem_word(32'h8);
        chk("s2_pc2", if_pc, 32'h8);
        chk("s2_opcode2", {25'b0, if_opcode}, {25'b0, w[6:0]});
        repeat (4) begin
            @(negedge clk);
            chk("s2_stream_valid", {31'b0, if_valid}, 32'd1);
        end

        // Decode stalled from reset: only FETCH_DEPTH requests go out
        tick(1);
        rst_n = 1'b0;
        if_ready = 1'b0;
        tick(2);
        rst_n = 1'b1;
        base = hs_cnt;
        tick(8);
        @(negedge clk);
        chk("s3_req_count", 32'(hs_cnt - base), 32'(DEPTH));
        chk("s3_req_stopped", {31'b0, imem_req_valid}, 32'd0);
        chk("s3_head_valid", {31'b0, if_valid}, 32'd1);
        tick(1);
        if_ready = 1'b1;
        tick(6);

        // Refill the FIFO, then reset with it full
        if_ready = 1'b0;
        tick(6);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("s6_if_valid", {31'b0, if_valid}, 32'd0);
        chk("s6_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("s6_addr", imem_req_addr, RPC);
        tick(1);
        if_ready = 1'b1;
        tick(5);

        // Redirect with fetches in flight on a slow memory
        lat = 3;
        tick(6);
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        tick(1);
        redirect_valid = 1'b0;
        wait_valid("s4_valid");
        chk("s4_pc", if_pc, 32'h200);
        tick(4);

        // Back-to-back redirects: the last one wins
        lat = 2;
        redirect_valid = 1'b1;
        redirect_pc = 32'h300;
        tick(1);
        redirect_pc = 32'h404;
        tick(1);
        redirect_valid = 1'b0;
        wait_valid("b2b_valid");
        chk("b2b_pc", if_pc, 32'h404);
        tick(4);

        // Unaligned target and PC wrap
        lat = 1;
        tick(3);
        redirect_valid = 1'b1;
        redirect_pc = 32'h103;
        tick(1);
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("s5_align", imem_req_addr, 32'h100);
        tick(3);
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick(1);
        redirect_valid = 1'b0;
        wait_valid("s5_wrap_valid");
        chk("s5_wrap_pc0", if_pc, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("s5_wrap_pc1", if_pc, 32'h0);
        tick(2);

        // Mixed back-pressure on both sides with occasional redirects
        lat = 2;
        for (int i = 0; i < 80; i++) begin
            if_ready       = 1'($urandom_range(0, 3) != 0);
            imem_req_ready = 1'($urandom_range(0, 3) != 0);
            redirect_valid = 1'($urandom_range(0, 15) == 0);
            redirect_pc    = 32'($urandom_range(0, 1023)) + 32'h1000;
            tick(1);
        end

        // Drain: nothing lost, nothing duplicated
        redirect_valid = 1'b0;
        imem_req_ready = 1'b0;
        if_ready = 1'b1;
        tick(10);
        @(negedge clk);
        chk("drain_sb_empty", 32'(sb.size()), 32'd0);
        chk("drain_if_valid", {31'b0, if_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, %0d vectors, %0d miscompares", vec, errs);
        $fatal(1, "timeout");
    end

endmodule
